mul_arbiter: RTL and testbench
==============================

// Module: mul_arbiter
// PURPOSE
//  Shares one 32x32 run/stall multiplier between two requesters (port A: CPU
//  execute stage, port B: coprocessor/DMA address unit). Latches operands,
//  sequences the multiplier's run/stall protocol, captures the 64-bit product
//  and returns it with a one-cycle ack. Sits between the requesters and the
//  single multiplier instance.
// PARAMETERS
//  W      32  operand width; product is 2*W
//  FIRST  0   port that wins the first contention after reset (0=A, 1=B)
// PORTS
//  clk     in   1    system clock, all state on rising edge
//  rst     in   1    synchronous reset, active-high
//  a_req   in   1    A requests a multiply; held with operands until a_ack
//  a_u     in   1    A signed mode (1 = two's-complement operands)
//  a_x     in   W    A multiplicand
//  a_y     in   W    A multiplier
//  a_ack   out  1    one-cycle pulse: a_z valid this cycle
//  b_req, b_u, b_x, b_y, b_ack   as port A, for requester B
//  z       out  2W   product register, shared by both ports; valid with ack
//  busy    out  1    high in RUN or DONE
//  m_run   out  1    multiplier run
//  m_u     out  1    multiplier signed mode (latched)
//  m_x     out  W    multiplier operand x (latched)
//  m_y     out  W    multiplier operand y (latched)
//  m_stall in   1    multiplier stall; product valid when m_run & ~m_stall
//  m_z     in   2W   multiplier product
// BEHAVIOUR
//  Reset: state=IDLE; m_run, a_ack, b_ack, busy = 0; z = 0; m_u/m_x/m_y = 0;
//   last-grant = ~FIRST so port FIRST wins the next contention.
//  Reset applies in any state; an in-flight op is abandoned, no ack is issued.
//  FSM, states IDLE -> RUN -> DONE -> IDLE:
//   IDLE: if no req, stay. If exactly one req, grant it. If both, grant the
//    port not equal to last-grant (round-robin). On grant: latch u/x/y into
//    m_u/m_x/m_y, record gnt, set last-grant=gnt, go RUN.
//   RUN: m_run=1, operands stable. While m_stall=1, stay (any stall length).
//    On m_stall=0: z <= m_z, go DONE.
//   DONE: m_run=0 (guarantees one idle cycle so the multiplier's internal state
//    clears before the next op); pulse ack of gnt if its req is still high,
//    else no ack (result discarded); go IDLE.
//  Latency with 1-cycle stall: req seen in IDLE at cycle t -> m_run t+1..t+2,
//   ack at t+3. Each extra stall cycle adds one cycle. Throughput: 1 op / 4 cyc.
//  Requester rule: keep req and operands stable until ack; drop req in the ack
//   cycle or re-assert for a new op. A req still high in the cycle after ack
//   is a new request. Operand changes after grant have no effect.
//  Req arriving for the other port during RUN/DONE waits; it is granted in the
//   next IDLE cycle, and under contention wins by round-robin.
//  Dropping req mid-op: op completes, multiplier is sequenced normally,
//   ack is suppressed, z is still updated.
//  z holds its value until the next capture; only one ack high in any cycle.
//  Width: m_z passed through unmodified; sign handling is the multiplier's
//   (m_u), no truncation or extension in this block.
// TESTING
//  1 A unsigned: x=0xFFFFFFFF, y=2 -> a_ack at t+3, z=0x00000001_FFFFFFFE, b_ack 0.
//  2 B signed: x=-3, y=5, u=1 -> b_ack, z=0xFFFFFFFF_FFFFFFF1; m_run high 2 cycles.
//  3 A and B both request continuously, A: 7*6, B: 9*9 -> acks alternate A,B,A,B
//    after reset (FIRST=0), z=42 then 81, one op every 4 cycles, no overlap.
//  4 Multiplier model stalls 3 cycles -> ack at t+5, m_x/m_y stable throughout,
//    operands changed by requester after grant do not alter z.
//  5 rst asserted in RUN -> next cycle m_run=0, busy=0, no ack; op from A
//    re-issued after reset completes correctly.
//  6 A drops a_req in RUN -> no a_ack, z updated, B pending req granted next IDLE.

Source files
------------

// File: rtl/mul_arbiter_if.sv
// Bundle between two multiply requesters, the arbiter and the shared multiplier.
// Latency: none, wires only.
// Backpressure: requesters hold req until ack; the multiplier stalls the arbiter via m_stall.
// Signals:
//   a_*/b_*   requester ports: req, u (signed mode), x, y in; ack out
//   z, busy   shared product register and arbiter activity flag
//   m_*       multiplier side: run, u, x, y out; stall, z in
// Modports: slave = arbiter view, master = requester/multiplier view.
interface mul_arbiter_if #(
    parameter int W = 32
);
    logic             a_req;
    logic             a_u;
    logic [W-1:0]     a_x;
    logic [W-1:0]     a_y;
    logic             a_ack;

    logic             b_req;
    logic             b_u;
    logic [W-1:0]     b_x;
    logic [W-1:0]     b_y;
    logic             b_ack;

    logic [2*W-1:0]   z;
    logic             busy;

    logic             m_run;
    logic             m_u;
    logic [W-1:0]     m_x;
    logic [W-1:0]     m_y;
    logic             m_stall;
    logic [2*W-1:0]   m_z;

    modport slave (
        input  a_req, a_u, a_x, a_y,
        input  b_req, b_u, b_x, b_y,
        input  m_stall, m_z,
        output a_ack, b_ack, z, busy,
        output m_run, m_u, m_x, m_y
    );

    modport master (
        output a_req, a_u, a_x, a_y,
        output b_req, b_u, b_x, b_y,
        output m_stall, m_z,
        input  a_ack, b_ack, z, busy,
        input  m_run, m_u, m_x, m_y
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin share of one run/stall multiplier between requesters A and B.
// Latency: req in IDLE at t -> ack at t+2+stall_cycles; one op per 3+stall_cycles cycles.
// Backpressure: requesters hold req until ack; m_stall holds RUN for any length.
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       mul_arbiter_if.slave: requester A/B handshakes, shared z/busy,
//             multiplier run/operand outputs and stall/product inputs
module mul_arbiter #(
    parameter int W     = 32,
    parameter bit FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    mul_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;      // 0 = A, 1 = B
    logic             last_q, last_d;    // port granted most recently
    logic             m_u_q, m_u_d;
    logic [W-1:0]     m_x_q, m_x_d;
    logic [W-1:0]     m_y_q, m_y_d;
    logic [2*W-1:0]   z_q, z_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            // Pretend the other port went last so FIRST wins the first contention.
            last_q  <= ~FIRST;
            m_u_q   <= 1'b0;
            m_x_q   <= '0;
            m_y_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            m_u_q   <= m_u_d;
            m_x_q   <= m_x_d;
            m_y_q   <= m_y_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        m_u_d   = m_u_q;
        m_x_d   = m_x_q;
        m_y_d   = m_y_q;
        z_d     = z_q;

        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    // Under contention the port that did not go last wins.
                    if (bus.a_req && bus.b_req) begin
                        gnt_d = ~last_q;
                    end else begin
                        gnt_d = bus.b_req;
                    end
                    last_d  = gnt_d;
                    m_u_d   = gnt_d ? bus.b_u : bus.a_u;
                    m_x_d   = gnt_d ? bus.b_x : bus.a_x;
                    m_y_d   = gnt_d ? bus.b_y : bus.a_y;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.m_stall) begin
                    z_d     = bus.m_z;
                    state_d = DONE;
                end
            end
            DONE: begin
                // m_run is low here, giving the multiplier one idle cycle between ops.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ack only if the granted requester is still asking; otherwise the result is dropped.
    assign bus.a_ack = (state_q == DONE) && !gnt_q && bus.a_req;
    assign bus.b_ack = (state_q == DONE) &&  gnt_q && bus.b_req;
    assign bus.z     = z_q;
    assign bus.busy  = (state_q == RUN) || (state_q == DONE);
    assign bus.m_run = (state_q == RUN);
    assign bus.m_u   = m_u_q;
    assign bus.m_x   = m_x_q;
    assign bus.m_y   = m_y_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter with a stalling multiplier model and a transaction-level expectation model.
// Latency: n/a.
// Backpressure: multiplier model stalls for stall_len cycles of each run.
module tb_mul_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   stall_len;
    int   run_cnt;
    logic model_last;   // port expected to have been granted most recently

    mul_arbiter_if #(.W(32)) bus ();

    mul_arbiter #(.W(32), .FIRST(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full-width product with sign or zero extension of the operands.
    function automatic logic [63:0] ref_mul(input logic u, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex;
        logic [63:0] ey;
        ex = u ? {{32{x[31]}}, x} : {32'b0, x};
        ey = u ? {{32{y[31]}}, y} : {32'b0, y};
        return ex * ey;
    endfunction

    // Multiplier model: stalls the first stall_len cycles of each run, junk product while stalled.
    always @(posedge clk) begin
        if (bus.m_run) run_cnt <= run_cnt + 1;
        else           run_cnt <= 0;
    end
    assign bus.m_stall = bus.m_run && (run_cnt < stall_len);
    assign bus.m_z     = bus.m_stall ? 64'hDEAD_BEEF_DEAD_BEEF : ref_mul(bus.m_u, bus.m_x, bus.m_y);

    task automatic clear_inputs();
        bus.a_req = 1'b0; bus.a_u = 1'b0; bus.a_x = '0; bus.a_y = '0;
        bus.b_req = 1'b0; bus.b_u = 1'b0; bus.b_x = '0; bus.b_y = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    // Steps negedges until an ack is seen or the limit expires; n = negedges stepped.
    task automatic wait_ack(input int limit, output int n, output logic ga, output logic gb);
        n = 0; ga = 1'b0; gb = 1'b0;
        while (n < limit && !ga && !gb) begin
            @(negedge clk);
            n++;
            ga = bus.a_ack;
            gb = bus.b_ack;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.m_run !== 1'b0) begin bad++; $display("FAIL reset_m_run got=%0b exp=0", bus.m_run); end
        total++; if (bus.a_ack !== 1'b0 || bus.b_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0b%0b exp=00", bus.a_ack, bus.b_ack); end
        total++; if (bus.z !== 64'd0)     begin bad++; $display("FAIL reset_z got=%h exp=0", bus.z); end
        total++; if (bus.m_x !== 32'd0 || bus.m_y !== 32'd0 || bus.m_u !== 1'b0) begin
            bad++; $display("FAIL reset_operands got=%h %h %0b exp=0 0 0", bus.m_x, bus.m_y, bus.m_u);
        end
    endtask

    task automatic test_a_unsigned();
        int n; logic ga, gb;
        stall_len = 1;
        bus.a_req = 1'b1; bus.a_u = 1'b0; bus.a_x = 32'hFFFF_FFFF; bus.a_y = 32'd2;
        wait_ack(10, n, ga, gb);
        bus.a_req = 1'b0;
        total++; if (n !== 3)              begin bad++; $display("FAIL a_unsigned_latency got=%0d exp=3", n); end
        total++; if (ga !== 1'b1 || gb !== 1'b0) begin bad++; $display("FAIL a_unsigned_acks got=%0b%0b exp=10", ga, gb); end
        total++; if (bus.z !== 64'h0000_0001_FFFF_FFFE) begin bad++; $display("FAIL a_unsigned_z got=%h exp=00000001fffffffe", bus.z); end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.a_ack !== 1'b0) begin bad++; $display("FAIL a_unsigned_after got=%0b%0b exp=00", bus.busy, bus.a_ack); end
        model_last = 1'b0;
    endtask

    task automatic test_b_signed();
        int runs;
        stall_len = 1;
        runs = 0;
        bus.b_req = 1'b1; bus.b_u = 1'b1; bus.b_x = -32'sd3; bus.b_y = 32'd5;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (bus.m_run === 1'b1) runs++;
            if (i < 3) begin
                total++; if (bus.b_ack !== 1'b0 || bus.a_ack !== 1'b0) begin bad++; $display("FAIL b_signed_early_ack step=%0d got=%0b%0b exp=00", i, bus.a_ack, bus.b_ack); end
            end
        end
        total++; if (bus.b_ack !== 1'b1) begin bad++; $display("FAIL b_signed_ack got=%0b exp=1", bus.b_ack); end
        total++; if (bus.z !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("FAIL b_signed_z got=%h exp=fffffffffffffff1", bus.z); end
        total++; if (runs !== 2) begin bad++; $display("FAIL b_signed_run_cycles got=%0d exp=2", runs); end
        bus.b_req = 1'b0;
        @(negedge clk);
        model_last = 1'b1;
    endtask

    task automatic test_contention();
        int n; logic ga, gb; logic exp_b; logic [63:0] exp_z;
        do_reset();
        stall_len = 1;
        bus.a_req = 1'b1; bus.a_u = 1'b0; bus.a_x = 32'd7; bus.a_y = 32'd6;
        bus.b_req = 1'b1; bus.b_u = 1'b0; bus.b_x = 32'd9; bus.b_y = 32'd9;
        for (int k = 0; k < 4; k++) begin
            exp_b = ~model_last;
            exp_z = exp_b ? 64'd81 : 64'd42;
            wait_ack(12, n, ga, gb);
            total++; if (n !== ((k == 0) ? 3 : 4)) begin bad++; $display("FAIL contention_interval k=%0d got=%0d exp=%0d", k, n, (k == 0) ? 3 : 4); end
            total++; if (ga !== !exp_b || gb !== exp_b) begin bad++; $display("FAIL contention_order k=%0d got=%0b%0b exp=%0b%0b", k, ga, gb, !exp_b, exp_b); end
            total++; if (bus.z !== exp_z) begin bad++; $display("FAIL contention_z k=%0d got=%0d exp=%0d", k, bus.z, exp_z); end
            model_last = exp_b;
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_long_stall();
        int n; logic ga, gb;
        stall_len = 3;
        bus.a_req = 1'b1; bus.a_u = 1'b0; bus.a_x = 32'd1000; bus.a_y = 32'd3;
        n = 0; ga = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++; if (bus.m_x !== 32'd1000 || bus.m_y !== 32'd3 || bus.m_run !== 1'b1) begin
                bad++; $display("FAIL long_stall_operands step=%0d got=%0d %0d run=%0b exp=1000 3 run=1", i, bus.m_x, bus.m_y, bus.m_run);
            end
            if (bus.a_ack === 1'b1) ga = 1'b1;
            if (i == 1) begin bus.a_x = 32'd77; bus.a_y = 32'd55; end
        end
        total++; if (ga !== 1'b0) begin bad++; $display("FAIL long_stall_early_ack got=1 exp=0"); end
        wait_ack(6, n, ga, gb);
        total++; if (n !== 1 || ga !== 1'b1) begin bad++; $display("FAIL long_stall_latency got=%0d ack=%0b exp=1 ack=1", n + 4, ga); end
        total++; if (bus.z !== 64'd3000) begin bad++; $display("FAIL long_stall_z got=%0d exp=3000", bus.z); end
        bus.a_req = 1'b0;
        @(negedge clk);
        model_last = 1'b0;
    endtask

    task automatic test_reset_in_run();
        int n; logic ga, gb;
        stall_len = 1;
        bus.a_req = 1'b1; bus.a_u = 1'b0; bus.a_x = 32'd6; bus.a_y = 32'd7;
        @(negedge clk);
        total++; if (bus.m_run !== 1'b1) begin bad++; $display("FAIL rst_run_start got=%0b exp=1", bus.m_run); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.m_run !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rst_run_abort got=%0b%0b exp=00", bus.m_run, bus.busy); end
        total++; if (bus.a_ack !== 1'b0 || bus.z !== 64'd0) begin bad++; $display("FAIL rst_run_state ack=%0b z=%0d exp=0 0", bus.a_ack, bus.z); end
        rst = 1'b0;
        model_last = 1'b1;
        wait_ack(10, n, ga, gb);
        total++; if (n !== 3 || ga !== 1'b1) begin bad++; $display("FAIL rst_reissue got=%0d ack=%0b exp=3 ack=1", n, ga); end
        total++; if (bus.z !== 64'd42) begin bad++; $display("FAIL rst_reissue_z got=%0d exp=42", bus.z); end
        bus.a_req = 1'b0;
        @(negedge clk);
        model_last = 1'b0;
    endtask

    task automatic test_drop_mid();
        int n; logic ga, gb;
        stall_len = 1;
        bus.a_req = 1'b1; bus.a_u = 1'b0; bus.a_x = 32'd11; bus.a_y = 32'd13;
        @(negedge clk);
        bus.a_req = 1'b0;
        bus.b_req = 1'b1; bus.b_u = 1'b0; bus.b_x = 32'd4; bus.b_y = 32'd5;
        repeat (2) @(negedge clk);
        total++; if (bus.a_ack !== 1'b0 || bus.b_ack !== 1'b0) begin bad++; $display("FAIL drop_ack got=%0b%0b exp=00", bus.a_ack, bus.b_ack); end
        total++; if (bus.z !== 64'd143) begin bad++; $display("FAIL drop_z got=%0d exp=143", bus.z); end
        wait_ack(10, n, ga, gb);
        total++; if (n !== 4 || gb !== 1'b1 || ga !== 1'b0) begin bad++; $display("FAIL drop_b_grant got=%0d acks=%0b%0b exp=4 acks=01", n, ga, gb); end
        total++; if (bus.z !== 64'd20) begin bad++; $display("FAIL drop_b_z got=%0d exp=20", bus.z); end
        bus.b_req = 1'b0;
        @(negedge clk);
        model_last = 1'b1;
    endtask

    task automatic test_random();
        int n; logic ga, gb; int mask; logic win;
        logic [63:0] pa, pb;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            mask = $urandom_range(3, 1);
            stall_len = $urandom_range(3, 0);
            bus.a_u = 1'($urandom); bus.a_x = $urandom; bus.a_y = $urandom;
            bus.b_u = 1'($urandom); bus.b_x = $urandom; bus.b_y = $urandom;
            pa = ref_mul(bus.a_u, bus.a_x, bus.a_y);
            pb = ref_mul(bus.b_u, bus.b_x, bus.b_y);
            bus.a_req = mask[0];
            bus.b_req = mask[1];
            win = (mask == 3) ? ~model_last : (mask == 2);
            wait_ack(12, n, ga, gb);
            total++; if (n !== 2 + stall_len || ga !== !win || gb !== win) begin
                bad++; $display("FAIL rand_first it=%0d got=%0d acks=%0b%0b exp=%0d acks=%0b%0b", it, n, ga, gb, 2 + stall_len, !win, win);
            end
            total++; if (bus.z !== (win ? pb : pa)) begin bad++; $display("FAIL rand_first_z it=%0d got=%h exp=%h", it, bus.z, win ? pb : pa); end
            if (win) bus.b_req = 1'b0; else bus.a_req = 1'b0;
            model_last = win;
            if (mask == 3) begin
                wait_ack(12, n, ga, gb);
                total++; if (n !== 3 + stall_len || ga !== win || gb !== !win) begin
                    bad++; $display("FAIL rand_second it=%0d got=%0d acks=%0b%0b exp=%0d acks=%0b%0b", it, n, ga, gb, 3 + stall_len, win, !win);
                end
                total++; if (bus.z !== (win ? pa : pb)) begin bad++; $display("FAIL rand_second_z it=%0d got=%h exp=%h", it, bus.z, win ? pa : pb); end
                bus.a_req = 1'b0; bus.b_req = 1'b0;
                model_last = ~win;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        stall_len = 1;
        run_cnt = 0;
        model_last = 1'b1;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_a_unsigned();
        test_b_signed();
        test_contention();
        test_long_stall();
        test_reset_in_run();
        test_drop_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
